// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated-memory model.
package simmem_pkg;

    localparam int IDWidth             = 4;
    localparam int DelayWidth          = 6;
    localparam int WriteRespSchedSlots = 8;

    // Lifecycle of one write-response scheduler slot.
    typedef enum logic [1:0] {
        SlotFree     = 2'd0,
        SlotCounting = 2'd1,
        SlotExpired  = 2'd2
    } wresp_slot_state_e;

    // Per-slot payload: the AXI ID and the remaining delay.
    typedef struct packed {
        logic [IDWidth-1:0]    id;
        logic [DelayWidth-1:0] counter;
    } wresp_sched_entry_t;

endpackage

// File: rtl/simmem_age_matrix.sv
// Relative-age tracker for a set of slots. Row i holds a bit per slot that
// is older than slot i. Freed slots have their row and column cleared, so a
// free slot's column is always zero and a new allocation only has to load
// its own row with the set of currently occupied slots.
module simmem_age_matrix #(
    parameter int NumSlots = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumSlots-1:0]                alloc_i,
    input  logic [NumSlots-1:0]                free_i,
    input  logic [NumSlots-1:0]                mask_i,
    output logic [NumSlots-1:0][NumSlots-1:0]  older_o,
    output logic [NumSlots-1:0]                oldest_o
);

    logic [NumSlots-1:0]               valid_reg;
    logic [NumSlots-1:0][NumSlots-1:0] older_reg;

    // Track occupancy and update age rows on allocate/free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_reg <= '0;
            older_reg <= '0;
        end else begin
            valid_reg <= (valid_reg | alloc_i) & ~free_i;
            for (int i = 0; i < NumSlots; i++) begin
                if (free_i[i]) begin
                    older_reg[i] <= '0;
                end else if (alloc_i[i]) begin
                    // Newcomer is younger than every slot that stays occupied.
                    older_reg[i] <= valid_reg & ~free_i;
                end else begin
                    older_reg[i] <= older_reg[i] & ~free_i;
                end
            end
        end
    end

    assign older_o = older_reg;

    // A masked slot is the oldest when no older slot is also in the mask.
    for (genvar gi = 0; gi < NumSlots; gi++) begin : g_oldest
        assign oldest_o[gi] = mask_i[gi] & ~|(older_reg[gi] & mask_i);
    end

endmodule

// File: rtl/simmem_wresp_scheduler.sv
// Write-response release scheduler: each accepted write waits its programmed
// delay, then is released oldest-first while keeping per-ID order.
module simmem_wresp_scheduler
    import simmem_pkg::*;
#(
    parameter int NumSlots = WriteRespSchedSlots,
    parameter int IdW      = IDWidth,
    parameter int DelayW   = DelayWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          sched_valid_i,
    output logic                          sched_ready_o,
    input  logic [IdW-1:0]                sched_id_i,
    input  logic [DelayW-1:0]             sched_delay_i,
    output logic                          release_valid_o,
    input  logic                          release_ready_i,
    output logic [IdW-1:0]                release_id_o,
    output logic [$clog2(NumSlots+1)-1:0] occupancy_o
);

    localparam int IdxW = $clog2(NumSlots);
    localparam int OccW = $clog2(NumSlots+1);

    wresp_slot_state_e  state_reg  [NumSlots];
    wresp_slot_state_e  state_next [NumSlots];
    wresp_sched_entry_t entry_reg  [NumSlots];
    wresp_sched_entry_t entry_next [NumSlots];

    logic [NumSlots-1:0]               free_mask;
    logic [NumSlots-1:0]               occ_mask;
    logic [NumSlots-1:0]               expired_mask;
    logic [NumSlots-1:0]               eligible;
    logic [NumSlots-1:0]               sel_onehot;
    logic [NumSlots-1:0]               alloc_onehot;
    logic [NumSlots-1:0]               free_onehot;
    logic [NumSlots-1:0][NumSlots-1:0] older;
    logic [NumSlots-1:0][NumSlots-1:0] same_id;

    logic            hold_valid_reg;
    logic [IdxW-1:0] hold_idx_reg;
    logic [IdxW-1:0] fresh_idx;
    logic [IdxW-1:0] sel_idx;
    logic [OccW-1:0] occ_reg;
    logic            accept;
    logic            fire;

    // Per-slot status vectors and the same-ID blocking rule.
    for (genvar gi = 0; gi < NumSlots; gi++) begin : g_slot
        assign free_mask[gi]    = (state_reg[gi] == SlotFree);
        assign expired_mask[gi] = (state_reg[gi] == SlotExpired);
        assign occ_mask[gi]     = ~free_mask[gi];
        for (genvar gj = 0; gj < NumSlots; gj++) begin : g_cmp
            assign same_id[gi][gj] = (entry_reg[gj].id == entry_reg[gi].id);
        end
        // An expired slot waits while any older live slot carries its ID.
        assign eligible[gi] = expired_mask[gi] & ~|(older[gi] & occ_mask & same_id[gi]);
    end

    // Ready depends on slot state only; a slot freed this cycle is not free yet.
    assign sched_ready_o = |free_mask;
    assign accept        = sched_valid_i & sched_ready_o;
    assign alloc_onehot  = accept ? (free_mask & (~free_mask + NumSlots'(1))) : '0;

    simmem_age_matrix #(
        .NumSlots (NumSlots)
    ) u_age_matrix (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .alloc_i  (alloc_onehot),
        .free_i   (free_onehot),
        .mask_i   (eligible),
        .older_o  (older),
        .oldest_o (sel_onehot)
    );

    // Encode the oldest eligible slot.
    always_comb begin
        fresh_idx = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (sel_onehot[i]) begin
                fresh_idx = IdxW'(i);
            end
        end
    end

    // A stalled release keeps presenting the same slot until it is taken.
    assign sel_idx         = hold_valid_reg ? hold_idx_reg : fresh_idx;
    assign release_valid_o = hold_valid_reg | (|eligible);
    assign release_id_o    = release_valid_o ? entry_reg[sel_idx].id : '0;
    assign fire            = release_valid_o & release_ready_i;
    assign free_onehot     = fire ? (NumSlots'(1) << sel_idx) : '0;
    assign occupancy_o     = occ_reg;

    // Slot next-state: load on allocate, count down, free on release.
    always_comb begin
        for (int i = 0; i < NumSlots; i++) begin
            state_next[i] = state_reg[i];
            entry_next[i] = entry_reg[i];
            case (state_reg[i])
                SlotFree: begin
                    if (alloc_onehot[i]) begin
                        entry_next[i].id      = sched_id_i;
                        entry_next[i].counter = sched_delay_i;
                        state_next[i] = (sched_delay_i == '0) ? SlotExpired : SlotCounting;
                    end
                end
                SlotCounting: begin
                    if (entry_reg[i].counter <= DelayW'(1)) begin
                        entry_next[i].counter = '0;
                        state_next[i] = SlotExpired;
                    end else begin
                        entry_next[i].counter = entry_reg[i].counter - DelayW'(1);
                    end
                end
                SlotExpired: begin
                    if (free_onehot[i]) begin
                        state_next[i] = SlotFree;
                    end
                end
                default: begin
                    state_next[i] = SlotFree;
                end
            endcase
        end
    end

    // Slot state and payload registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) begin
                state_reg[i] <= SlotFree;
                entry_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                state_reg[i] <= state_next[i];
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    // Hold register latches the presented slot while the bank stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_reg <= 1'b0;
            hold_idx_reg   <= '0;
        end else if (fire) begin
            hold_valid_reg <= 1'b0;
        end else if (release_valid_o) begin
            hold_valid_reg <= 1'b1;
            hold_idx_reg   <= sel_idx;
        end
    end

    // Occupancy counter: +1 per accept, -1 per release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_reg <= '0;
        end else if (accept && !fire) begin
            occ_reg <= occ_reg + OccW'(1);
        end else if (fire && !accept) begin
            occ_reg <= occ_reg - OccW'(1);
        end
    end

endmodule

// File: tb/tb_simmem_wresp_scheduler.sv
// Self-checking bench for simmem_wresp_scheduler with a release-order scoreboard.
module tb_simmem_wresp_scheduler;

    logic       clk;
    logic       rst_n;
    logic       sched_valid;
    logic       sched_ready;
    logic [3:0] sched_id;
    logic [5:0] sched_delay;
    logic       release_valid;
    logic       release_ready;
    logic [3:0] release_id;
    logic [3:0] occupancy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [3:0] exp_q[$];

    simmem_wresp_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .sched_valid_i   (sched_valid),
        .sched_ready_o   (sched_ready),
        .sched_id_i      (sched_id),
        .sched_delay_i   (sched_delay),
        .release_valid_o (release_valid),
        .release_ready_i (release_ready),
        .release_id_o    (release_id),
        .occupancy_o     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard plus bench-side invariants, sampled on the falling edge.
    logic       prev_hold = 1'b0;
    logic [3:0] prev_id   = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (!release_valid || release_id !== prev_id) begin
                    errors++;
                    $display("FAIL hold_stable got valid=%0b id=%0d exp valid=1 id=%0d", release_valid, release_id, prev_id);
                end
            end
            checks++;
            if (occupancy > 4'd8) begin
                errors++;
                $display("FAIL occ_bound got=%0d exp<=8", occupancy);
            end
            if (release_valid && release_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_release got id=%0d exp none (cycle %0d)", release_id, cyc);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if (release_id !== e) begin
                        errors++;
                        $display("FAIL release_order got id=%0d exp id=%0d (cycle %0d)", release_id, e, cyc);
                    end
                end
            end
            prev_hold = release_valid && !release_ready;
            prev_id   = release_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sched(input logic [3:0] id, input logic [5:0] d);
        sched_valid = 1'b1;
        sched_id    = id;
        sched_delay = d;
        tick();
        sched_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (release_valid) begin
                at = cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sched_valid = 1'b0; sched_id = '0; sched_delay = '0; release_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(); #1;
        checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", sched_ready); end
        checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", release_valid); end
        checks++; if (release_id !== 4'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", release_id); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        $display("txn reset done");
    endtask

    task automatic test_single();
        int t, at;
        t = cyc;
        exp_q.push_back(4'd3);
        sched(4'd3, 6'd5);
        wait_valid(20, at);
        checks++; if (at !== t + 6) begin errors++; $display("FAIL single_time got=%0d exp=%0d", at, t + 6); end
        checks++; if (release_id !== 4'd3) begin errors++; $display("FAIL single_id got=%0d exp=3", release_id); end
        tick(); #1;
        checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%0b exp=0", release_valid); end
        $display("txn single id=3 delay=5 released at T+%0d", at - t);
    endtask

    task automatic test_zero_delay();
        exp_q.push_back(4'd1);
        sched(4'd1, 6'd0);
        #1;
        checks++; if (release_valid !== 1'b1 || release_id !== 4'd1) begin errors++; $display("FAIL zero_valid got v=%0b id=%0d exp v=1 id=1", release_valid, release_id); end
        tick(); #1;
        checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL zero_drop got=%0b exp=0", release_valid); end
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd1);
        sched_valid = 1'b1; sched_id = 4'd1; sched_delay = 6'd0;
        tick(); #1;
        checks++; if (release_valid !== 1'b1 || release_id !== 4'd1) begin errors++; $display("FAIL b2b_first got v=%0b id=%0d exp v=1 id=1", release_valid, release_id); end
        tick(); sched_valid = 1'b0; #1;
        checks++; if (release_valid !== 1'b1 || release_id !== 4'd1) begin errors++; $display("FAIL b2b_second got v=%0b id=%0d exp v=1 id=1", release_valid, release_id); end
        tick(); #1;
        checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got=%0b exp=0", release_valid); end
        $display("txn zero-delay and back-to-back id=1");
    endtask

    task automatic test_accept_release();
        int t, at;
        t = cyc;
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd9);
        sched(4'd8, 6'd0);
        #1;
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL ar_occ1 got=%0d exp=1", occupancy); end
        sched(4'd9, 6'd3);
        #1;
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL ar_occ_same got=%0d exp=1", occupancy); end
        wait_valid(20, at);
        checks++; if (at !== t + 5 || release_id !== 4'd9) begin errors++; $display("FAIL ar_second got t=%0d id=%0d exp t=%0d id=9", at, release_id, t + 5); end
        tick(); #1;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL ar_occ0 got=%0d exp=0", occupancy); end
        $display("txn accept+release same cycle, id=8 then id=9");
    endtask

    task automatic test_same_id();
        int t, at;
        t = cyc;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd2);
        sched(4'd2, 6'd10);
        sched(4'd2, 6'd1);
        wait_valid(30, at);
        checks++; if (at !== t + 11 || release_id !== 4'd2) begin errors++; $display("FAIL same_first got t=%0d id=%0d exp t=%0d id=2", at, release_id, t + 11); end
        tick(); #1;
        checks++; if (release_valid !== 1'b1 || release_id !== 4'd2) begin errors++; $display("FAIL same_second got v=%0b id=%0d exp v=1 id=2", release_valid, release_id); end
        tick(); #1;
        checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL same_drop got=%0b exp=0", release_valid); end
        $display("txn same-id ordering id=2 delays 10,1");
    endtask

    task automatic test_cross_id();
        int t, at;
        t = cyc;
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd4);
        sched(4'd4, 6'd8);
        sched(4'd5, 6'd2);
        wait_valid(20, at);
        checks++; if (at !== t + 4 || release_id !== 4'd5) begin errors++; $display("FAIL cross_first got t=%0d id=%0d exp t=%0d id=5", at, release_id, t + 4); end
        tick();
        wait_valid(20, at);
        checks++; if (at !== t + 9 || release_id !== 4'd4) begin errors++; $display("FAIL cross_second got t=%0d id=%0d exp t=%0d id=4", at, release_id, t + 9); end
        tick();
        $display("txn cross-id reorder id=5 before id=4");
    endtask

    task automatic test_backpressure();
        int t, at;
        release_ready = 1'b0;
        t = cyc;
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd7);
        sched(4'd7, 6'd6);
        sched(4'd6, 6'd1);
        wait_valid(20, at);
        checks++; if (at !== t + 3 || release_id !== 4'd6) begin errors++; $display("FAIL bp_first got t=%0d id=%0d exp t=%0d id=6", at, release_id, t + 3); end
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            checks++; if (release_valid !== 1'b1 || release_id !== 4'd6) begin errors++; $display("FAIL bp_hold got v=%0b id=%0d exp v=1 id=6", release_valid, release_id); end
        end
        release_ready = 1'b1;
        #1;
        checks++; if (release_id !== 4'd6) begin errors++; $display("FAIL bp_at_ready got=%0d exp=6", release_id); end
        tick(); #1;
        checks++; if (release_valid !== 1'b1 || release_id !== 4'd7) begin errors++; $display("FAIL bp_next got v=%0b id=%0d exp v=1 id=7", release_valid, release_id); end
        tick(); #1;
        checks++; if (release_valid !== 1'b0) begin errors++; $display("FAIL bp_drop got=%0b exp=0", release_valid); end
        $display("txn backpressure held id=6 then id=7");
    endtask

    task automatic test_full_reset();
        int seen;
        for (int i = 0; i < 8; i++) begin
            sched_valid = 1'b1; sched_id = 4'(i); sched_delay = 6'd63;
            tick();
        end
        #1;
        checks++; if (sched_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", sched_ready); end
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
        sched_id = 4'd9;
        tick(); sched_valid = 1'b0; #1;
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_blocked got=%0d exp=8", occupancy); end
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        checks++; if (release_valid !== 1'b0 || release_id !== 4'd0) begin errors++; $display("FAIL rst_release got v=%0b id=%0d exp v=0 id=0", release_valid, release_id); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(); #1;
        checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", sched_ready); end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick(); #1;
            if (release_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL stale_release got=%0d valid cycles exp=0", seen); end
        $display("txn full fill, mid-count reset, no stale release");
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_delay();
        test_accept_release();
        test_same_id();
        test_cross_id();
        test_backpressure();
        test_full_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/simmem_wresp_scheduler.md
Name: simmem_wresp_scheduler

Overview:
- Release scheduler for the simulated-memory write-response path.
- For each accepted write address, holds the AXI ID and a programmed delay. When the delay expires, grants release of one write response for that ID to the write-response bank.
- Sits between the write-address ingress (delay calculator) and the write-response bank's release port.
- Preserves AXI per-ID response ordering; responses with different IDs may be reordered by delay.

Parameters:
- NumSlots, 8, number of concurrently tracked outstanding writes; power of two, 2..32.
- IdW, simmem_pkg::IDWidth (4), AXI ID width.
- DelayW, simmem_pkg::DelayWidth (6), delay field width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- sched_valid_i  in  1  new write to schedule
- sched_ready_o  out  1  a free slot exists
- sched_id_i  in  IdW  AXI ID of the write
- sched_delay_i  in  DelayW  release delay in cycles (0..2^DelayW-1)
- release_valid_o  out  1  a response may be released
- release_ready_i  in  1  bank consumed the release
- release_id_o  out  IdW  ID whose oldest response is released
- occupancy_o  out  $clog2(NumSlots+1)  occupied slot count

Behaviour:
- One clock; reset asynchronous active-low, applied on clk_i.
- On reset:
  - all slots FREE; age matrix cleared; hold register cleared.
  - sched_ready_o=1 (once out of reset); release_valid_o=0; release_id_o=0; occupancy_o=0.
- Per-slot FSM: FREE -> COUNTING -> EXPIRED -> FREE.
- Accept:
  - Handshake is sched_valid_i & sched_ready_o.
  - sched_ready_o = any slot FREE in the current cycle; combinational from state only, never from release_ready_i.
  - The lowest-index FREE slot is loaded with id and counter=sched_delay_i.
  - delay 0 -> EXPIRED; otherwise -> COUNTING.
  - The new slot is marked younger than every occupied slot.
- Counting:
  - A COUNTING slot decrements every cycle.
  - At an edge with counter==1 it moves to EXPIRED.
  - A write accepted at cycle T is eligible at cycle T+d+1 for every d, including 0.
  - The counter never underflows and never wraps.
- Eligibility:
  - A slot is eligible when it is EXPIRED and no older occupied slot (COUNTING or EXPIRED) has the same ID.
  - A short-delay same-ID write therefore waits behind a long-delay older one.
- Selection: among eligible slots, the oldest wins, taken from the age matrix.
- Output:
  - release_valid_o = held | any eligible.
  - release_id_o = ID of the selected slot; 0 when not valid.
- Stability:
  - If release_valid_o=1 and release_ready_i=0, the selected slot index is latched in the hold register.
  - release_id_o then stays constant until the handshake completes, even if an older slot becomes eligible.
- Release:
  - On release_valid_o & release_ready_i the selected slot goes FREE at the next edge and the hold register clears.
  - Its age row and column are cleared.
- Simultaneous accept and release in one cycle:
  - Both complete.
  - A slot freed that cycle is not reused until the next cycle.
  - occupancy_o is unchanged.
- Full:
  - sched_ready_o=0.
  - Counting and release continue.
  - The first release reasserts sched_ready_o in the following cycle.
- occupancy_o is a registered count, updated +1/-1/0 per edge.
- Reset asserted mid-operation discards all pending releases immediately (asynchronous); no partial state survives.
- Assertions (bench-side):
  - release_id_o stable while valid & !ready.
  - occupancy_o <= NumSlots.
  - No two same-ID releases out of acceptance order.

Decomposition:
- simmem_pkg additions:
  - localparam WriteRespSchedSlots=8.
  - Slot-state enum type wresp_slot_state_e {SlotFree, SlotCounting, SlotExpired}.
  - Packed struct wresp_sched_entry_t {id, counter}.
- Sub-module simmem_age_matrix (NumSlots):
  - Inputs: alloc one-hot, free one-hot.
  - Outputs: per-slot older-than vectors and the oldest-of-mask select.
  - Reused later by the read-data scheduler.

Test Plan:
- Single write: id=3, delay=5 accepted at T -> release_valid_o rises at T+6 with release_id_o=3; with release_ready_i=1 it drops at T+7.
- Zero delay: id=1, delay=0 at T -> valid at T+1. Back-to-back id=1 delay=0 at T, T+1 with ready=1 -> releases at T+1 and T+2.
- Same-ID ordering: id=2 delay=10 at T, id=2 delay=1 at T+1 -> first release at T+11, second at T+12; nothing for id 2 before T+11.
- Cross-ID reorder: id=4 delay=8 at T, id=5 delay=2 at T+1 -> id 5 released first (T+4), id 4 at T+9.
- Backpressure stability: id=6 expires, release_ready_i=0 for 5 cycles while an older id=7 expires -> release_id_o holds 6; id 7 follows after the handshake.
- Full and reset: fill 8 slots with delay=63 -> sched_ready_o=0, occupancy_o=8; assert rst_ni low mid-count -> occupancy_o=0, release_valid_o=0 immediately; after deassert, sched_ready_o=1 and no stale release ever appears.
